// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame FSM states and default bit timing.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   // 6 MHz reference clock / 115200 baud
   localparam int unsigned DefClksPerBit = 52;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; pointers carry one extra bit so full/empty fall out of the difference.
module uart_tx_fifo #(
   parameter int unsigned Depth = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   level
);

   localparam int unsigned Aw = $clog2(Depth);
   localparam logic [Aw:0] FullLevel = (Aw + 1)'(Depth);

   logic [7:0]  mem [Depth];
   logic [Aw:0] wptr;
   logic [Aw:0] rptr;
   logic        do_push;
   logic        do_pop;

   assign level   = wptr - rptr;
   assign full    = (level == FullLevel);
   assign empty   = (level == '0);
   // A full FIFO refuses a push even when a pop lands in the same cycle
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr[Aw-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[Aw-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered 8-bit frames (start, 8 data LSB first, optional parity, stop).
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned ClksPerBit = DefClksPerBit,
   parameter int unsigned FifoDepth  = 4,
   parameter bit          ParityEn   = 1'b0,
   parameter bit          ParityOdd  = 1'b0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [7:0]                   tx_data_i,
   input  logic                         tx_valid_i,
   output logic                         tx_ready_o,
   output logic                         tx_o,
   output logic                         tx_en_o,
   output logic                         busy_o,
   output logic [$clog2(FifoDepth):0]   fifo_level_o
);

   localparam logic [15:0] LastCnt = 16'(ClksPerBit - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  data_q, data_d;
   logic        tx_q, tx_d;
   logic        en_q, en_d;
   logic        rdy_q;
   logic        bit_end;
   logic        pop;
   logic        full;
   logic        empty;
   logic [7:0]  head;

   uart_tx_fifo #(
      .Depth (FifoDepth)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .push  (tx_valid_i & tx_ready_o),
      .wdata (tx_data_i),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level_o)
   );

   // rdy_q keeps ready low throughout reset and raises it on the first edge after release
   assign tx_ready_o = rdy_q & ~full;
   assign busy_o     = (state_q != IDLE) | ~empty;
   assign tx_o       = tx_q;
   assign tx_en_o    = en_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
         en_q    <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         en_q    <= en_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      pop     = 1'b0;
      bit_end = (cnt_q == LastCnt);
      tx_d    = 1'b1;
      en_d    = 1'b0;

      if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 16'd1;

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               data_d  = head;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = ParityEn ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  data_d  = head;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is derived from the next state so tx_o/tx_en_o stay registered without a cycle of lag
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[idx_d];
         PARITY:  tx_d = (^data_d) ^ ParityOdd;
         default: tx_d = 1'b1;
      endcase
      en_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three parameter variants checked cycle by cycle against a frame-timing model.
module tb_uart_tx;

   localparam int Cpb   = 4;
   localparam int Depth = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid [3];
   logic [7:0] data  [3];
   logic       ready [3];
   logic       tx    [3];
   logic       en    [3];
   logic       busy  [3];
   logic [2:0] lvl   [3];

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] q [$];

   always #5 clk = ~clk;

   uart_tx #(.ClksPerBit(Cpb), .FifoDepth(Depth), .ParityEn(1'b0), .ParityOdd(1'b0)) u_plain (
      .clk_i(clk), .rst_ni(rst_n), .tx_data_i(data[0]), .tx_valid_i(valid[0]), .tx_ready_o(ready[0]),
      .tx_o(tx[0]), .tx_en_o(en[0]), .busy_o(busy[0]), .fifo_level_o(lvl[0]));

   uart_tx #(.ClksPerBit(Cpb), .FifoDepth(Depth), .ParityEn(1'b1), .ParityOdd(1'b0)) u_even (
      .clk_i(clk), .rst_ni(rst_n), .tx_data_i(data[1]), .tx_valid_i(valid[1]), .tx_ready_o(ready[1]),
      .tx_o(tx[1]), .tx_en_o(en[1]), .busy_o(busy[1]), .fifo_level_o(lvl[1]));

   uart_tx #(.ClksPerBit(Cpb), .FifoDepth(Depth), .ParityEn(1'b1), .ParityOdd(1'b1)) u_odd (
      .clk_i(clk), .rst_ni(rst_n), .tx_data_i(data[2]), .tx_valid_i(valid[2]), .tx_ready_o(ready[2]),
      .tx_o(tx[2]), .tx_en_o(en[2]), .busy_o(busy[2]), .fifo_level_o(lvl[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends every byte in q through instance k with valid held high, and checks the line against
   // the concatenated ideal frames: first start bit one cycle after the first handshake, no gaps.
   task automatic run_stream(input int k, input string tag);
      logic wave [$];
      int   n, frame, idx, h, pushes, pops, lvl_m, en_cnt, t;
      logic pend, in_frame, done, exp_tx;
      foreach (q[i]) begin
         wave.push_back(1'b0);
         for (int j = 0; j < 8; j++) wave.push_back(q[i][j]);
         if (k != 0) wave.push_back(logic'($countones(q[i]) % 2) ^ logic'(k == 2));
         wave.push_back(1'b1);
      end
      n      = q.size();
      frame  = (wave.size() / n) * Cpb;
      idx    = 0;
      h      = -1;
      pushes = 0;
      en_cnt = 0;
      pend   = 1'b0;
      done   = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         if (pend) begin
            pushes++;
            if (h < 0) h = c;
            pend = 1'b0;
         end
         pops = (h >= 0 && c > h) ? ((c - h - 1) / frame + 1) : 0;
         if (pops > n) pops = n;
         lvl_m    = pushes - pops;
         in_frame = (h >= 0) && (c > h) && (c <= h + n * frame);
         exp_tx   = 1'b1;
         if (in_frame) begin
            t      = c - h - 1;
            exp_tx = wave[t / Cpb];
         end
         check({tag, "/level"}, 32'(lvl[k]), 32'(lvl_m));
         check({tag, "/ready"}, 32'(ready[k]), 32'(lvl_m != Depth));
         check({tag, "/busy"}, 32'(busy[k]), 32'(in_frame || lvl_m != 0));
         check({tag, "/tx_en"}, 32'(en[k]), 32'(in_frame));
         check({tag, "/tx"}, 32'(tx[k]), 32'(exp_tx));
         if (en[k] === 1'b1) en_cnt++;
         if (h >= 0 && c >= h + n * frame + 3) done = 1'b1;
         if (idx < n) begin
            valid[k] = 1'b1;
            data[k]  = q[idx];
            if (ready[k] === 1'b1) begin
               pend = 1'b1;
               idx++;
            end
         end else begin
            valid[k] = 1'b0;
            data[k]  = 8'($urandom);
         end
      end
      valid[k] = 1'b0;
      check({tag, "/en_cycles"}, 32'(en_cnt), 32'(n * frame));
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         valid[k] = 1'b0;
         data[k]  = 8'h00;
      end

      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst/tx", 32'(tx[k]), 32'd1);
         check("rst/tx_en", 32'(en[k]), 32'd0);
         check("rst/busy", 32'(busy[k]), 32'd0);
         check("rst/level", 32'(lvl[k]), 32'd0);
         check("rst/ready", 32'(ready[k]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) check("rst/ready_after", 32'(ready[k]), 32'd1);

      q.delete(); q.push_back(8'h55);
      run_stream(0, "single55");

      q.delete(); q.push_back(8'hA3); q.push_back(8'h0F);
      run_stream(0, "b2b");

      q.delete();
      for (int i = 0; i < 6; i++) q.push_back(8'(8'h11 * (i + 1)));
      run_stream(0, "full6");

      q.delete(); q.push_back(8'h07);
      run_stream(1, "par_even");
      q.delete(); q.push_back(8'h07);
      run_stream(2, "par_odd");

      for (int r = 0; r < 6; r++) begin
         int k;
         int n;
         k = int'($urandom_range(0, 2));
         n = int'($urandom_range(1, 6));
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         run_stream(k, "rand");
      end

      // Reset in the middle of data bit 3 of 0x81 with two more bytes queued
      q.delete(); q.push_back(8'h81); q.push_back(8'($urandom)); q.push_back(8'($urandom));
      @(negedge clk); valid[0] = 1'b1; data[0] = q[0];
      @(negedge clk); data[0] = q[1];
      @(negedge clk); data[0] = q[2];
      @(negedge clk); valid[0] = 1'b0;
      repeat (16) @(negedge clk);
      check("midrst/pre_tx", 32'(tx[0]), 32'd0);
      check("midrst/pre_level", 32'(lvl[0]), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("midrst/tx", 32'(tx[0]), 32'd1);
      check("midrst/tx_en", 32'(en[0]), 32'd0);
      check("midrst/level", 32'(lvl[0]), 32'd0);
      check("midrst/busy", 32'(busy[0]), 32'd0);
      check("midrst/ready", 32'(ready[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         check("midrst/idle_tx", 32'(tx[0]), 32'd1);
         check("midrst/idle_en", 32'(en[0]), 32'd0);
         check("midrst/idle_level", 32'(lvl[0]), 32'd0);
         check("midrst/idle_busy", 32'(busy[0]), 32'd0);
      end

      q.delete(); q.push_back(8'($urandom));
      run_stream(0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
